// File: rtl/rob.sv
// rob: reorder buffer with in-order allocate, out-of-order completion, in-order retire and mispredict rewind.
// Optional ROB_COMMIT_BYPASS_EN: a completion broadcast that hits the head entry commits it in the same cycle.
module rob #(
    parameter int DEPTH  = 32,
    parameter int TAG_W  = 5,
    parameter int PREG_W = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_we,
    input  logic [PREG_W-1:0]    alloc_pd_new,
    input  logic [PREG_W-1:0]    alloc_pd_old,
    input  logic [31:0]          alloc_pc,
    output logic [TAG_W-1:0]     rob_tag_out,
    output logic                 rob_full_out,
    output logic [TAG_W-1:0]     head_tag_out,
    input  logic [2:0]           cmpl_valid,
    input  logic [3*TAG_W-1:0]   cmpl_tag,
    input  logic                 mispredict,
    input  logic [TAG_W-1:0]     mispredict_tag,
    output logic                 commit_valid,
    output logic [TAG_W-1:0]     commit_tag,
    output logic [PREG_W-1:0]    commit_pd_new,
    output logic [PREG_W-1:0]    commit_pd_old,
    output logic [31:0]          commit_pc,
    output logic                 commit_free_valid
);
    logic [DEPTH-1:0]  valid, done, cmpl_hit, squash;
    logic [PREG_W-1:0] pd_new [DEPTH];
    logic [PREG_W-1:0] pd_old [DEPTH];
    logic [31:0]       pc [DEPTH];
    logic [TAG_W-1:0]  head, tail, keep_span;
    logic [TAG_W:0]    count;
    logic              alloc_fire;

    assign rob_full_out = count == (TAG_W+1)'(DEPTH);
    assign alloc_fire = alloc_we && !rob_full_out && !mispredict;
    assign keep_span = mispredict_tag - head;
    assign rob_tag_out = tail;
    assign head_tag_out = head;
    assign commit_tag = head;
    assign commit_pd_new = pd_new[head];
    assign commit_pd_old = pd_old[head];
    assign commit_pc = pc[head];
`ifdef ROB_COMMIT_BYPASS_EN
    assign commit_valid = valid[head] && (done[head] || cmpl_hit[head]);
`else
    assign commit_valid = valid[head] && done[head];
`endif
    assign commit_free_valid = commit_valid && (commit_pd_new != '0);

    // Age is measured from head, so "younger than the branch" is a plain compare of offsets.
    always_comb begin
        cmpl_hit = '0;
        squash = '0;
        for (int j = 0; j < DEPTH; j++) begin
            for (int i = 0; i < 3; i++)
                if (cmpl_valid[i] && cmpl_tag[i*TAG_W +: TAG_W] == TAG_W'(j)) cmpl_hit[j] = 1'b1;
            squash[j] = mispredict && ((TAG_W'(j) - head) > keep_span);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            done <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (alloc_fire && tail == TAG_W'(j)) begin
                    valid[j] <= 1'b1;
                    done[j] <= 1'b0;
                end else if (squash[j] || (commit_valid && head == TAG_W'(j))) begin
                    valid[j] <= 1'b0;
                    done[j] <= 1'b0;
                end else if (cmpl_hit[j] && valid[j]) begin
                    done[j] <= 1'b1;
                end
            end
            if (commit_valid) head <= head + TAG_W'(1);
            tail <= mispredict ? mispredict_tag + TAG_W'(1) : tail + TAG_W'(alloc_fire);
            count <= mispredict ? {1'b0, keep_span} + (TAG_W+1)'(1) - (TAG_W+1)'(commit_valid)
                                : count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pd_new[tail] <= alloc_pd_new;
            pd_old[tail] <= alloc_pd_old;
            pc[tail] <= alloc_pc;
        end
    end
endmodule

// File: tb/tb_rob.sv
// tb_rob: randomized and directed checks of rob against a queue-based reorder buffer model.
module tb_rob;
    localparam int D = 32;
    logic        clk = 0, reset = 0, alloc_we = 0, mispredict = 0;
    logic [6:0]  alloc_pd_new = 0, alloc_pd_old = 0;
    logic [31:0] alloc_pc = 0;
    logic [2:0]  cmpl_valid = 0;
    logic [14:0] cmpl_tag = 0;
    logic [4:0]  mispredict_tag = 0;
    logic [4:0]  rob_tag_out, head_tag_out, commit_tag;
    logic        rob_full_out, commit_valid, commit_free_valid;
    logic [6:0]  commit_pd_new, commit_pd_old;
    logic [31:0] commit_pc;

    rob dut (
        .clk(clk), .reset(reset), .alloc_we(alloc_we), .alloc_pd_new(alloc_pd_new),
        .alloc_pd_old(alloc_pd_old), .alloc_pc(alloc_pc), .rob_tag_out(rob_tag_out),
        .rob_full_out(rob_full_out), .head_tag_out(head_tag_out), .cmpl_valid(cmpl_valid),
        .cmpl_tag(cmpl_tag), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_pd_new(commit_pd_new),
        .commit_pd_old(commit_pd_old), .commit_pc(commit_pc), .commit_free_valid(commit_free_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  tag;
        logic [6:0]  pn;
        logic [6:0]  po;
        logic [31:0] pc;
        bit          done;
    } ent_t;

    ent_t q[$];
    int   mhead, cmp, err;

    wire [12:0] st = {rob_tag_out, head_tag_out, rob_full_out, commit_valid, commit_free_valid};
    wire [50:0] cm = {commit_tag, commit_pd_new, commit_pd_old, commit_pc};

    function automatic bit hit(logic [4:0] t);
        for (int i = 0; i < 3; i++)
            if (cmpl_valid[i] && cmpl_tag[i*5 +: 5] == t) return 1;
        return 0;
    endfunction

    function automatic bit m_cv();
        if (q.size() == 0) return 0;
`ifdef ROB_COMMIT_BYPASS_EN
        return q[0].done || hit(q[0].tag);
`else
        return q[0].done;
`endif
    endfunction

    function automatic logic [12:0] exp_status();
        bit cv = m_cv();
        return {5'((mhead + q.size()) % D), 5'(mhead), q.size() == D, cv, cv && q[0].pn != 0};
    endfunction

    function automatic logic [50:0] exp_commit();
        if (q.size() == 0) return '0;
        return {q[0].tag, q[0].pn, q[0].po, q[0].pc};
    endfunction

    task automatic m_edge();
        bit full = q.size() == D;
        bit cv = m_cv();
        bit al = alloc_we && !full && !mispredict;
        int tail = (mhead + q.size()) % D;
        foreach (q[k]) if (hit(q[k].tag)) q[k].done = 1;
        if (mispredict) begin
            int keep = ((int'(mispredict_tag) - mhead) % D + D) % D + 1;
            while (q.size() > keep) void'(q.pop_back());
        end
        if (cv) begin
            void'(q.pop_front());
            mhead = (mhead + 1) % D;
        end
        if (al) q.push_back('{5'(tail), alloc_pd_new, alloc_pd_old, alloc_pc, 1'b0});
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic drive(bit we, bit [2:0] cv, bit [14:0] ct, bit mp, bit [4:0] mt);
        alloc_we = we;
        alloc_pd_new = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
        alloc_pd_old = 7'($urandom);
        alloc_pc = $urandom;
        cmpl_valid = cv;
        cmpl_tag = ct;
        mispredict = mp;
        mispredict_tag = mt;
    endtask

    task automatic do_reset();
        reset = 0;
        drive(0, 0, 0, 0, 0);
        q.delete();
        mhead = 0;
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 0, 0); tick(); end
        drive(0, 0, 0, 0, 0);
        #1;
        cmp++; if (st !== exp_status()) begin err++; $display("FAIL reset_pre got %h want %h", st, exp_status()); end
        #2 reset = 0;
        #1;
        cmp++; if (st !== 13'd0) begin err++; $display("FAIL reset_async got %h want 0", st); end
        q.delete();
        mhead = 0;
        @(negedge clk);
        reset = 1;
        drive(1, 0, 0, 0, 0);
        #1;
        cmp++; if (rob_tag_out !== 5'd0) begin err++; $display("FAIL reset_first_tag got %0d want 0", rob_tag_out); end
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        cmp++; if (st !== exp_status()) begin err++; $display("FAIL reset_post got %h want %h", st, exp_status()); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < D; i++) begin
            drive(1, 0, 0, 0, 0);
            #1;
            cmp++; if ({rob_tag_out, rob_full_out} !== {5'(i), 1'b0}) begin
                err++; $display("FAIL full_fill got tag %0d full %0d want tag %0d full 0", rob_tag_out, rob_full_out, i);
            end
            tick();
        end
        drive(1, 0, 0, 0, 0);
        #1;
        cmp++; if (st !== exp_status() || !rob_full_out) begin err++; $display("FAIL full_flag got %h want %h", st, exp_status()); end
        tick();
        drive(1, 3'b001, 15'd0, 0, 0);
        #1;
        cmp++; if ({rob_tag_out, rob_full_out} !== {5'd0, 1'b1}) begin
            err++; $display("FAIL full_drop got tag %0d full %0d want tag 0 full 1", rob_tag_out, rob_full_out);
        end
        if (!m_cv()) begin tick(); drive(1, 0, 0, 0, 0); #1; end
        cmp++; if ({commit_valid, commit_tag, rob_full_out} !== {1'b1, 5'd0, 1'b1}) begin
            err++; $display("FAIL full_commit got cv %0d tag %0d full %0d want 1 0 1", commit_valid, commit_tag, rob_full_out);
        end
        cmp++; if (cm !== exp_commit()) begin err++; $display("FAIL full_commit_data got %h want %h", cm, exp_commit()); end
        tick();
        drive(1, 0, 0, 0, 0);
        #1;
        cmp++; if ({rob_tag_out, rob_full_out} !== {5'd0, 1'b0}) begin
            err++; $display("FAIL full_realloc got tag %0d full %0d want tag 0 full 0", rob_tag_out, rob_full_out);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        cmp++; if (st !== exp_status() || !rob_full_out) begin err++; $display("FAIL full_refill got %h want %h", st, exp_status()); end
    endtask

    task automatic test_order();
        logic [19:0] seq = '0;
        int n = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0);
            if (i == 1) alloc_pd_new = 0;
            else if (alloc_pd_new == 0) alloc_pd_new = 7'd9;
            tick();
        end
        drive(0, 3'b001, 15'd2, 0, 0);
        tick();
        drive(0, 3'b001, 15'd0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            if (c == 1) drive(0, 3'b101, {5'd3, 5'd0, 5'd1}, 0, 0);
            else if (c > 1) drive(0, 0, 0, 0, 0);
            #1;
            cmp++; if (st !== exp_status()) begin err++; $display("FAIL order_status c%0d got %h want %h", c, st, exp_status()); end
            if (commit_valid) begin
                seq = {seq[14:0], commit_tag};
                n++;
                if (commit_tag == 5'd1) begin
                    cmp++; if (commit_free_valid !== 1'b0) begin err++; $display("FAIL order_free_pd0 got %0d want 0", commit_free_valid); end
                end
            end
            tick();
        end
        cmp++; if ({seq, 3'(n)} !== {5'd0, 5'd1, 5'd2, 5'd3, 3'd4}) begin
            err++; $display("FAIL order_seq got %h n %0d want 00443 n 4", seq, n);
        end
    endtask

    task automatic test_mispredict_wrap();
        do_reset();
        for (int i = 0; i < 30; i++) begin drive(1, 0, 0, 0, 0); tick(); end
        for (int i = 0; i < 10; i++) begin
            drive(0, 3'b111, {5'(3*i+2), 5'(3*i+1), 5'(3*i)}, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        for (int n = 0; n < 40 && q.size() > 0; n++) tick();
        #1;
        cmp++; if ({head_tag_out, commit_valid} !== {5'd30, 1'b0}) begin
            err++; $display("FAIL wrap_head got head %0d cv %0d want 30 0", head_tag_out, commit_valid);
        end
        for (int i = 0; i < 6; i++) begin drive(1, 0, 0, 0, 0); tick(); end
        drive(0, 0, 0, 1, 5'd31);
        #1;
        cmp++; if (st !== exp_status()) begin err++; $display("FAIL wrap_pre got %h want %h", st, exp_status()); end
        tick();
        drive(0, 3'b111, {5'd31, 5'd30, 5'd1}, 0, 0);
        #1;
        cmp++; if ({rob_tag_out, head_tag_out, rob_full_out} !== {5'd0, 5'd30, 1'b0}) begin
            err++; $display("FAIL wrap_rewind got tail %0d head %0d want 0 30", rob_tag_out, head_tag_out);
        end
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(c < 2, 0, 0, 0, 0);
            #1;
            cmp++; if (st !== exp_status()) begin err++; $display("FAIL wrap_status c%0d got %h want %h", c, st, exp_status()); end
            if (commit_valid) begin
                cmp++; if (cm !== exp_commit()) begin err++; $display("FAIL wrap_commit got %h want %h", cm, exp_commit()); end
            end
            tick();
        end
        #1;
        cmp++; if ({head_tag_out, rob_tag_out, commit_valid} !== {5'd0, 5'd2, 1'b0}) begin
            err++; $display("FAIL wrap_stale_cmpl got head %0d tail %0d cv %0d want 0 2 0", head_tag_out, rob_tag_out, commit_valid);
        end
    endtask

    task automatic test_mispredict_commit();
        int n = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin drive(1, 0, 0, 0, 0); tick(); end
        drive(0, 3'b001, 15'd0, 0, 0);
        #1;
        if (!m_cv()) begin tick(); drive(0, 0, 0, 0, 0); end
        cmpl_valid = cmpl_valid | 3'b110;
        cmpl_tag[14:5] = {5'd2, 5'd4};
        alloc_we = 1;
        mispredict = 1;
        mispredict_tag = 5'd3;
        #1;
        cmp++; if ({commit_valid, commit_tag} !== {1'b1, 5'd0}) begin
            err++; $display("FAIL mpc_commit got cv %0d tag %0d want 1 0", commit_valid, commit_tag);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        cmp++; if ({rob_tag_out, head_tag_out} !== {5'd4, 5'd1}) begin
            err++; $display("FAIL mpc_ptrs got tail %0d head %0d want 4 1", rob_tag_out, head_tag_out);
        end
        for (int k = 0; k < 40 && !rob_full_out; k++) begin drive(1, 0, 0, 0, 0); tick(); n++; end
        drive(0, 0, 0, 0, 0);
        #1;
        cmp++; if (n !== 29) begin err++; $display("FAIL mpc_count got %0d allocs to full want 29", n); end
        cmp++; if (st !== exp_status()) begin err++; $display("FAIL mpc_status got %h want %h", st, exp_status()); end
    endtask

    task automatic test_bypass();
        do_reset();
        for (int i = 0; i < 8; i++) begin drive(1, 0, 0, 0, 0); tick(); end
        for (int i = 0; i < 7; i++) begin drive(0, 3'b001, 15'(i), 0, 0); tick(); end
        drive(0, 0, 0, 0, 0);
        for (int n = 0; n < 10 && mhead != 7; n++) tick();
        drive(0, 3'b100, {5'd7, 10'd0}, 0, 0);
        #1;
`ifdef ROB_COMMIT_BYPASS_EN
        cmp++; if ({head_tag_out, commit_valid} !== {5'd7, 1'b1}) begin
            err++; $display("FAIL bypass_same got head %0d cv %0d want 7 1", head_tag_out, commit_valid);
        end
`else
        cmp++; if ({head_tag_out, commit_valid} !== {5'd7, 1'b0}) begin
            err++; $display("FAIL bypass_same got head %0d cv %0d want 7 0", head_tag_out, commit_valid);
        end
`endif
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
`ifdef ROB_COMMIT_BYPASS_EN
        cmp++; if ({head_tag_out, commit_valid} !== {5'd8, 1'b0}) begin
            err++; $display("FAIL bypass_next got head %0d cv %0d want 8 0", head_tag_out, commit_valid);
        end
`else
        cmp++; if ({head_tag_out, commit_valid} !== {5'd7, 1'b1}) begin
            err++; $display("FAIL bypass_next got head %0d cv %0d want 7 1", head_tag_out, commit_valid);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            logic [14:0] ct;
            bit mp = q.size() > 0 && $urandom_range(0, 19) == 0;
            logic [4:0] mt = mp ? q[$urandom_range(0, q.size() - 1)].tag : 5'd0;
            for (int i = 0; i < 3; i++)
                ct[i*5 +: 5] = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].tag : 5'($urandom);
            drive($urandom_range(0, 9) < 7, 3'($urandom), ct, mp, mt);
            #1;
            cmp++; if (st !== exp_status()) begin err++; $display("FAIL rand_status c%0d got %h want %h", c, st, exp_status()); end
            if (m_cv()) begin
                cmp++; if (cm !== exp_commit()) begin err++; $display("FAIL rand_commit c%0d got %h want %h", c, cm, exp_commit()); end
            end
            tick();
        end
    endtask

    initial begin
        cmp = 0;
        err = 0;
        test_reset();
        test_full();
        test_order();
        test_mispredict_wrap();
        test_mispredict_commit();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer: the allocation responder for the dispatch stage.
- Accepts one in-order allocation per cycle from dispatch and returns the tag for the next allocation plus a full flag.
- Marks entries done from the three completion broadcasts, retires at most one completed entry per cycle in program order, and rewinds its tail on branch mispredict.
- Retirement frees the old physical destination register back to the free list.

Parameters:
DEPTH, 32, number of entries; power of two
TAG_W, 5, tag width; equals log2(DEPTH)
PREG_W, 7, physical register index width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
alloc_we  in  1  dispatch allocation strobe
alloc_pd_new  in  PREG_W  new physical destination
alloc_pd_old  in  PREG_W  previous mapping of the architectural destination
alloc_pc  in  32  instruction PC
rob_tag_out  out  TAG_W  tag the next allocation receives (tail pointer)
rob_full_out  out  1  count == DEPTH
head_tag_out  out  TAG_W  tag of the oldest entry (head pointer)
cmpl_valid  in  3  completion broadcast valids, one bit per broadcast
cmpl_tag  in  3*TAG_W  completion tags; broadcast i at [i*TAG_W +: TAG_W]
mispredict  in  1  branch mispredict strobe
mispredict_tag  in  TAG_W  tag of the mispredicted branch
commit_valid  out  1  head entry retires this cycle
commit_tag  out  TAG_W  tag of the retiring entry
commit_pd_new  out  PREG_W  pd_new of the retiring entry
commit_pd_old  out  PREG_W  pd_old of the retiring entry
commit_pc  out  32  PC of the retiring entry
commit_free_valid  out  1  commit_valid && commit_pd_new != 0; free list releases commit_pd_old

Behaviour:
- State: per entry valid, done, pd_new, pd_old, pc; head and tail TAG_W pointers; count of TAG_W+1 bits.
- Reset (reset == 0, asynchronous): head = tail = count = 0; all valid and done = 0. Outputs: rob_tag_out 0, head_tag_out 0, rob_full_out 0, commit_valid 0, commit_free_valid 0.
- Allocation:
  - Fires when alloc_we && !rob_full_out && !mispredict.
  - Writes entry[tail] with valid = 1, done = 0; tail increments mod DEPTH.
  - alloc_we while full or during mispredict is dropped silently. Dispatch already gates on rob_full_out.
- Completion:
  - For each i with cmpl_valid[i], entry[cmpl_tag[i]].done is set next edge, only if that entry is valid.
  - Completion to an invalid (flushed or free) entry is ignored.
  - Duplicate tags across broadcasts are harmless.
  - If allocation and completion hit the same index in one cycle, allocation wins and done = 0.
- Commit:
  - commit_valid = entry[head].valid && entry[head].done, from registered state only.
  - Commit outputs show entry[head].
  - On commit: entry[head].valid and done clear; head increments mod DEPTH.
  - Latency: completion sampled at edge N gives commit_valid in cycle N+1 at the earliest.
- Count:
  - Alloc and commit in the same cycle: count unchanged.
  - Alloc only: +1. Commit only: -1.
  - Wrap-around of head and tail is mod DEPTH; full versus empty is resolved by count, never by pointer equality.
- Mispredict, single-cycle, no FSM stall:
  - tail_next = mispredict_tag + 1 mod DEPTH.
  - Entries strictly younger than mispredict_tag (from mispredict_tag+1 up to old tail-1) get valid = 0 and done = 0.
  - Surviving count = ((mispredict_tag - head) mod DEPTH) + 1, minus 1 if a commit fires the same cycle. Range 0..DEPTH.
  - Commit in the mispredict cycle proceeds normally.
  - Completions in that cycle to squashed tags are dropped.
  - Completions to surviving tags are kept.
- Simultaneous full-and-commit: rob_full_out reflects pre-edge count, so no allocation in that cycle; the freed slot is usable next cycle.

Optional Feature:
ROB_COMMIT_BYPASS_EN
- Defined: commit_valid also asserts when entry[head].valid and any cmpl_valid[i] matches head in the same cycle. Zero-cycle completion-to-commit; adds a combinational path from the completion broadcasts to commit.
- Undefined: commit uses only registered done, as above.

Test Plan:
1. Reset low mid-run with count 5 -> immediately head 0, tail 0, rob_full_out 0, commit_valid 0; after release, the first alloc receives tag 0.
2. Alloc 32 entries back-to-back -> rob_full_out = 1 after the 32nd edge; 33rd alloc_we is dropped and tail stays 0. Complete tag 0, then commit tag 0; the next alloc receives tag 0.
3. Alloc tags 0..3, complete 2, then 0, then 1 and 3 on two broadcasts in one cycle -> commits in order 0, 1, 2, 3 on consecutive cycles. pd_new = 0 entry gives commit_free_valid = 0.
4. Head = 30, tail = 4 (count 6); mispredict_tag = 31 -> tail = 0, count = 2, tags 0..3 invalid. A later completion on tag 1 is ignored.
5. Mispredict, alloc_we and commit of head in the same cycle -> alloc dropped, commit retires, count = (tag - head + 1) - 1.
6. With ROB_COMMIT_BYPASS_EN defined: head tag 7, cmpl_valid = 3'b100 with tag 7 -> commit_valid in the same cycle. Without the macro -> commit_valid one cycle later.
